prim_generic_ram_2p_sc: RTL and testbench

Single-clock, true dual-port SRAM model. Successor to the generic 2-port register model, adding:
- reset-time memory scrub with a grant handshake
- configurable read latency with rvalid strobes
- defined same-address collision semantics
- out-of-range address handling for non-power-of-2 depths

Used as a drop-in simulation/FPGA memory for blocks clocked from one domain.

---
 rtl/prim_generic_ram_2p_sc.sv | 211 +++++++++++++++++++++
 tb/tb_prim_generic_ram_2p_sc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_generic_ram_2p_sc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prim_generic_ram_2p_sc: single-clock true dual-port RAM with reset scrub,
// 1/2-cycle read latency and defined collisions. Optional: PRIM_RAM_2P_COLLISION_CNT_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
module prim_generic_ram_2p_sc #(
  parameter int               Width           = 32,
  parameter int               Depth           = 128,
  parameter int               DataBitsPerMask = 1,
  parameter int               ReadLatency     = 1,
  parameter bit               WriteFirst      = 1'b0,
  parameter logic [Width-1:0] InitValue       = '0,
  localparam int              Aw              = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             init_done_o,
  input  logic             a_req_i,
  output logic             a_gnt_o,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  output logic             b_gnt_o,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o
`ifdef PRIM_RAM_2P_COLLISION_CNT_EN
  ,
  output logic [15:0]      collision_cnt_o
`endif
);

  localparam int            Groups = Width / DataBitsPerMask;
  localparam logic [Aw:0]   DepthW = (Aw + 1)'(Depth);

  typedef enum logic [0:0] {StInit = 1'b0, StReady = 1'b1} state_e;

  state_e          r_state, w_state_nxt;
  logic [Aw-1:0]   r_cnt, w_cnt_nxt;
  logic            w_scrub_we;
  logic [Width-1:0] r_mem [Depth];

  logic [1:0]        w_req, w_write, w_gnt, w_we, w_re, w_inrange, w_rvalid;
  logic [Aw-1:0]     w_addr    [2];
  logic [Width-1:0]  w_wdata   [2];
  logic [Width-1:0]  w_wmask   [2];
  logic [Groups-1:0] w_grp_en  [2];
  logic [Width-1:0]  w_old     [2];
  logic [Width-1:0]  w_merged  [2];
  logic [Width-1:0]  w_rd_word [2];
  logic [Width-1:0]  w_rdata   [2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_scrub_we  = 1'b0;
    unique case (r_state)
      StInit: begin
        w_scrub_we = 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == Aw'(Depth - 1)) w_state_nxt = StReady;
      end
      default: ;
    endcase
  end

  // Reset masks the done flag immediately so no request is granted in a reset cycle.
  assign init_done_o = (r_state == StReady) && !rst_i;

  assign w_req   = {b_req_i, a_req_i};
  assign w_write = {b_write_i, a_write_i};
  assign w_addr[0]  = a_addr_i;
  assign w_addr[1]  = b_addr_i;
  assign w_wdata[0] = a_wdata_i;
  assign w_wdata[1] = b_wdata_i;
  assign w_wmask[0] = a_wmask_i;
  assign w_wmask[1] = b_wmask_i;

  assign w_gnt   = w_req & {2{init_done_o}};
  assign a_gnt_o = w_gnt[0];
  assign b_gnt_o = w_gnt[1];

  function automatic logic [Width-1:0] f_merge(input logic [Width-1:0]  base,
                                               input logic [Width-1:0]  wdata,
                                               input logic [Groups-1:0] en);
    f_merge = base;
    for (int g = 0; g < Groups; g++) begin
      if (en[g]) f_merge[g*DataBitsPerMask +: DataBitsPerMask] = wdata[g*DataBitsPerMask +: DataBitsPerMask];
    end
  endfunction

  // Merged word at each port's address: B groups first, then A groups on top, so A wins.
  always_comb begin
    w_grp_en  = '{default: '0};
    w_old     = '{default: '0};
    w_merged  = '{default: '0};
    w_rd_word = '{default: '0};
    w_inrange = '0;
    w_we      = '0;
    w_re      = '0;
    for (int p = 0; p < 2; p++) begin
      for (int g = 0; g < Groups; g++) begin
        w_grp_en[p][g] = &w_wmask[p][g*DataBitsPerMask +: DataBitsPerMask];
      end
      w_inrange[p] = ({1'b0, w_addr[p]} < DepthW);
      w_we[p]      = w_gnt[p] && w_write[p] && w_inrange[p];
      w_re[p]      = w_gnt[p] && !w_write[p];
    end
    for (int p = 0; p < 2; p++) begin
      w_old[p]    = w_inrange[p] ? r_mem[w_addr[p]] : '0;
      w_merged[p] = w_old[p];
      if (w_we[1] && (w_addr[1] == w_addr[p])) w_merged[p] = f_merge(w_merged[p], w_wdata[1], w_grp_en[1]);
      if (w_we[0] && (w_addr[0] == w_addr[p])) w_merged[p] = f_merge(w_merged[p], w_wdata[0], w_grp_en[0]);
      w_rd_word[p] = WriteFirst ? w_merged[p] : w_old[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_scrub_we) r_mem[r_cnt] <= InitValue;
      for (int p = 0; p < 2; p++) begin
        if (w_we[p]) r_mem[w_addr[p]] <= w_merged[p];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic             r_rvalid;
    logic [Width-1:0] r_rdata;
    if (ReadLatency == 2) begin : g_lat2
      logic             r_pvalid;
      logic [Width-1:0] r_pdata;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_pvalid <= 1'b0;
          r_pdata  <= '0;
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
        end else begin
          r_pvalid <= w_re[p];
          if (w_re[p]) r_pdata <= w_rd_word[p];
          r_rvalid <= r_pvalid;
          if (r_pvalid) r_rdata <= r_pdata;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
        end else begin
          r_rvalid <= w_re[p];
          if (w_re[p]) r_rdata <= w_rd_word[p];
        end
      end
    end
    assign w_rvalid[p] = r_rvalid;
    assign w_rdata[p]  = r_rdata;
  end

  assign a_rvalid_o = w_rvalid[0];
  assign b_rvalid_o = w_rvalid[1];
  assign a_rdata_o  = w_rdata[0];
  assign b_rdata_o  = w_rdata[1];

`ifdef PRIM_RAM_2P_COLLISION_CNT_EN
  logic        w_coll;
  logic [15:0] r_coll_cnt;
  assign w_coll = (&w_gnt) && (w_addr[0] == w_addr[1]) && w_inrange[0] && (|w_write);
  always_ff @(posedge clk_i) begin
    if (rst_i) r_coll_cnt <= '0;
    else if (w_coll && (r_coll_cnt != 16'hFFFF)) r_coll_cnt <= r_coll_cnt + 16'd1;
  end
  assign collision_cnt_o = r_coll_cnt;
`endif

  function automatic logic f_uniform(input logic [Width-1:0] m);
    f_uniform = 1'b1;
    for (int g = 0; g < Groups; g++) begin
      if (!((&m[g*DataBitsPerMask +: DataBitsPerMask]) || !(|m[g*DataBitsPerMask +: DataBitsPerMask])))
        f_uniform = 1'b0;
    end
  endfunction

  a_mask_uniform_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (a_gnt_o && a_write_i) |-> f_uniform(a_wmask_i));
  a_mask_uniform_b: assert property (@(posedge clk_i) disable iff (rst_i)
    (b_gnt_o && b_write_i) |-> f_uniform(b_wmask_i));
  a_latency_legal:  assert property (@(posedge clk_i) (ReadLatency == 1) || (ReadLatency == 2));
  a_mask_divides:   assert property (@(posedge clk_i) (Width % DataBitsPerMask) == 0);

endmodule
`default_nettype wire

// File: tb/tb_prim_generic_ram_2p_sc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prim_generic_ram_2p_sc: two configurations of the RAM against a word-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_prim_generic_ram_2p_sc;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [6:0]  a_addr, b_addr;
  logic [31:0] a_wd, a_wm, b_wd, b_wm;

  logic [1:0]  done, a_gnt, b_gnt, a_rv, b_rv;
  logic [31:0] a_rd [2];
  logic [31:0] b_rd [2];
  logic [15:0] ccnt [2];

  int          DEP  [2] = '{100, 128};
  int          RLAT [2] = '{2, 1};
  bit          WF   [2] = '{1'b1, 1'b0};
  int          GB   [2] = '{8, 1};
  logic [31:0] IV   [2] = '{32'h5A5A0F0F, 32'hDEADBEEF};

  logic [31:0] mm   [2][128];
  bit          mdone [2];
  int          mcnt  [2];
  int          coll  [2];
  bit          sv   [2][2][4];
  logic [31:0] sd   [2][2][4];
  logic [31:0] hold [2][2];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  prim_generic_ram_2p_sc #(
    .Width(32), .Depth(100), .DataBitsPerMask(8), .ReadLatency(2),
    .WriteFirst(1'b1), .InitValue(32'h5A5A0F0F)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .init_done_o(done[0]),
    .a_req_i(a_req), .a_gnt_o(a_gnt[0]), .a_write_i(a_we), .a_addr_i(a_addr),
    .a_wdata_i(a_wd), .a_wmask_i(a_wm), .a_rvalid_o(a_rv[0]), .a_rdata_o(a_rd[0]),
    .b_req_i(b_req), .b_gnt_o(b_gnt[0]), .b_write_i(b_we), .b_addr_i(b_addr),
    .b_wdata_i(b_wd), .b_wmask_i(b_wm), .b_rvalid_o(b_rv[0]), .b_rdata_o(b_rd[0])
`ifdef PRIM_RAM_2P_COLLISION_CNT_EN
    , .collision_cnt_o(ccnt[0])
`endif
  );

  prim_generic_ram_2p_sc #(
    .Width(32), .Depth(128), .DataBitsPerMask(1), .ReadLatency(1),
    .WriteFirst(1'b0), .InitValue(32'hDEADBEEF)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .init_done_o(done[1]),
    .a_req_i(a_req), .a_gnt_o(a_gnt[1]), .a_write_i(a_we), .a_addr_i(a_addr),
    .a_wdata_i(a_wd), .a_wmask_i(a_wm), .a_rvalid_o(a_rv[1]), .a_rdata_o(a_rd[1]),
    .b_req_i(b_req), .b_gnt_o(b_gnt[1]), .b_write_i(b_we), .b_addr_i(b_addr),
    .b_wdata_i(b_wd), .b_wmask_i(b_wm), .b_rvalid_o(b_rv[1]), .b_rdata_o(b_rd[1])
`ifdef PRIM_RAM_2P_COLLISION_CNT_EN
    , .collision_cnt_o(ccnt[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit grp_on(input logic [31:0] m, input int g, input int gb);
    for (int j = g * gb; j < (g + 1) * gb; j++) if (!m[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Word at adr once this edge's granted writes land (A beats B bit by bit).
  function automatic logic [31:0] after_w(input int n, input int adr);
    logic [31:0] w;
    if (adr >= DEP[n]) return 32'h0;
    w = mm[n][adr];
    for (int i = 0; i < 32; i++) begin
      int g = i / GB[n];
      if (a_req && a_we && int'(a_addr) == adr && grp_on(a_wm, g, GB[n])) w[i] = a_wd[i];
      else if (b_req && b_we && int'(b_addr) == adr && grp_on(b_wm, g, GB[n])) w[i] = b_wd[i];
    end
    return w;
  endfunction

  task automatic model_edge();
    int e = cyc + 1;
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        mdone[n] = 1'b0; mcnt[n] = 0; coll[n] = 0;
        for (int p = 0; p < 2; p++) begin
          hold[n][p] = 32'h0;
          for (int k = 0; k < 4; k++) sv[n][p][k] = 1'b0;
        end
      end else if (!mdone[n]) begin
        mm[n][mcnt[n]] = IV[n];
        mcnt[n]++;
        if (mcnt[n] == DEP[n]) mdone[n] = 1'b1;
      end else begin
        int s = (e + RLAT[n] - 1) % 4;
        logic [31:0] wa, wb;
        wa = after_w(n, int'(a_addr));
        wb = after_w(n, int'(b_addr));
        if (a_req && !a_we) begin
          sv[n][0][s] = 1'b1;
          sd[n][0][s] = WF[n] ? wa : ((int'(a_addr) < DEP[n]) ? mm[n][a_addr] : 32'h0);
        end
        if (b_req && !b_we) begin
          sv[n][1][s] = 1'b1;
          sd[n][1][s] = WF[n] ? wb : ((int'(b_addr) < DEP[n]) ? mm[n][b_addr] : 32'h0);
        end
        if (a_req && a_we && int'(a_addr) < DEP[n]) mm[n][a_addr] = wa;
        if (b_req && b_we && int'(b_addr) < DEP[n]) mm[n][b_addr] = wb;
        if (a_req && b_req && a_addr == b_addr && int'(a_addr) < DEP[n] && (a_we || b_we) && coll[n] < 65535)
          coll[n]++;
      end
    end
  endtask

  task automatic post_check();
    int s = cyc % 4;
    for (int n = 0; n < 2; n++) begin
      bit dn = mdone[n] && !rst;
      bit ev [2];
      for (int p = 0; p < 2; p++) begin
        ev[p] = sv[n][p][s];
        if (ev[p]) hold[n][p] = sd[n][p][s];
        sv[n][p][s] = 1'b0;
      end
      check($sformatf("u%0d.init_done", n), 32'(done[n]), 32'(dn));
      check($sformatf("u%0d.a_gnt", n), 32'(a_gnt[n]), 32'(a_req && dn));
      check($sformatf("u%0d.b_gnt", n), 32'(b_gnt[n]), 32'(b_req && dn));
      check($sformatf("u%0d.a_rvalid", n), 32'(a_rv[n]), 32'(ev[0]));
      check($sformatf("u%0d.b_rvalid", n), 32'(b_rv[n]), 32'(ev[1]));
      check($sformatf("u%0d.a_rdata", n), a_rd[n], hold[n][0]);
      check($sformatf("u%0d.b_rdata", n), b_rd[n], hold[n][1]);
`ifdef PRIM_RAM_2P_COLLISION_CNT_EN
      check($sformatf("u%0d.coll_cnt", n), 32'(ccnt[n]), 32'(coll[n]));
`endif
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    post_check();
  endtask

  task automatic set_a(input logic rq, input logic we, input logic [6:0] ad, input logic [31:0] wd, input logic [31:0] wm);
    a_req = rq; a_we = we; a_addr = ad; a_wd = wd; a_wm = wm;
  endtask

  task automatic set_b(input logic rq, input logic we, input logic [6:0] ad, input logic [31:0] wd, input logic [31:0] wm);
    b_req = rq; b_we = we; b_addr = ad; b_wd = wd; b_wm = wm;
  endtask

  task automatic idle(input int k);
    set_a(1'b0, 1'b0, 7'd0, 32'h0, 32'h0);
    set_b(1'b0, 1'b0, 7'd0, 32'h0, 32'h0);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic wait_init();
    int guard = 0;
    while (!(mdone[0] && mdone[1]) && guard < 300) begin
      cycle();
      guard++;
    end
    check("init_timeout", 32'(done), 32'h3);
  endtask

  function automatic logic [31:0] rnd_mask();
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [6:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return 7'($urandom_range(0, 127));
      1:       return 7'($urandom_range(96, 103));
      default: return 7'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    set_a(1'b1, 1'b1, 7'd5, 32'h1, 32'hFFFFFFFF);
    set_b(1'b1, 1'b0, 7'd5, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;
    set_b(1'b0, 1'b0, 7'd0, 32'h0, 32'h0);
    wait_init();
    idle(2);

    set_a(1'b1, 1'b0, 7'd0, 32'h0, 32'h0);   set_b(1'b1, 1'b0, 7'd64, 32'h0, 32'h0);  cycle();
    set_a(1'b1, 1'b0, 7'd127, 32'h0, 32'h0); set_b(1'b1, 1'b0, 7'd99, 32'h0, 32'h0);  cycle();
    set_a(1'b1, 1'b0, 7'd5, 32'h0, 32'h0);   set_b(1'b1, 1'b0, 7'd5, 32'h0, 32'h0);   cycle();
    idle(3);

    for (int i = 1; i <= 3; i++) begin
      set_a(1'b1, 1'b0, 7'(i), 32'h0, 32'h0);
      cycle();
    end
    idle(3);

    set_a(1'b1, 1'b1, 7'd9, 32'hAAAAAAAA, 32'h0000FFFF);
    set_b(1'b1, 1'b1, 7'd9, 32'hBBBBBBBB, 32'hFFFFFFFF);
    cycle();
    idle(0);
    set_a(1'b1, 1'b0, 7'd9, 32'h0, 32'h0);
    cycle();
    idle(3);

    set_a(1'b1, 1'b1, 7'd3, 32'h0, 32'hFFFFFFFF);
    cycle();
    set_a(1'b1, 1'b1, 7'd3, 32'h55, 32'hFFFFFFFF);
    set_b(1'b1, 1'b0, 7'd3, 32'h0, 32'h0);
    cycle();
    idle(3);

    for (int i = 0; i < 800; i++) begin
      set_a($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, rnd_addr(), $urandom, rnd_mask());
      set_b($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, rnd_addr(), $urandom, rnd_mask());
      cycle();
    end
    idle(3);

    set_a(1'b1, 1'b0, 7'd99, 32'h0, 32'h0);
    cycle();
    idle(0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_init();
    idle(1);
    set_a(1'b1, 1'b0, 7'd100, 32'h0, 32'h0);
    set_b(1'b1, 1'b0, 7'd99, 32'h0, 32'h0);
    cycle();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
